// File: rtl/if_fetch_sequencer.sv
// Fetch sequencer: issues sequential 8-byte-aligned I-cache requests and stages in-order
// responses in a credit-protected skid FIFO that drains into the fetch buffer.
module if_fetch_sequencer #(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_0000_1000,
  parameter int          SKID_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        ic_req_valid,
  output logic [63:0] ic_req_addr,
  input  logic        ic_req_ready,
  input  logic        ic_resp_valid,
  input  logic [63:0] ic_resp_data,
  output logic        enq_valid,
  output logic [63:0] enq_data,
  input  logic        enq_ready,
  output logic [63:0] fetch_pc,
  output logic        err_unexpected_resp
);
  localparam int CW = $clog2(SKID_DEPTH) + 1;
  localparam int AW = $clog2(SKID_DEPTH);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t          state, state_nxt;
  logic [63:0]     pc;
  logic [CW-1:0]   in_flight, drop_cnt, skid_cnt;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [63:0]     skid_mem [SKID_DEPTH];
  logic [CW:0]     credit_used;
  logic            req_hs, resp_ok, skid_wr, skid_pop;
  logic            unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fetch_en)  state_nxt = FETCH;
      FETCH:   if (!fetch_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Every request must have a guaranteed skid slot for its response.
  assign credit_used = {1'b0, in_flight} + {1'b0, skid_cnt};

  always_comb begin
    ic_req_valid = (state == FETCH) && !redirect_valid &&
                   (credit_used < (CW+1)'(SKID_DEPTH));
    enq_valid    = (skid_cnt != '0) && !redirect_valid;
  end

  assign ic_req_addr = pc;
  assign fetch_pc    = pc;
  assign enq_data    = skid_mem[rd_ptr];

  assign req_hs   = ic_req_valid && ic_req_ready;
  assign resp_ok  = ic_resp_valid && (in_flight != '0);
  assign skid_wr  = resp_ok && (drop_cnt == '0) && !redirect_valid;
  assign skid_pop = enq_valid && enq_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc                  <= RESET_PC;
      in_flight           <= '0;
      drop_cnt            <= '0;
      err_unexpected_resp <= 1'b0;
    end else begin
      in_flight <= in_flight + CW'(req_hs) - CW'(resp_ok);
      if (ic_resp_valid && (in_flight == '0))
        err_unexpected_resp <= 1'b1;
      // A redirect re-counts every still-owed response as stale.
      if (redirect_valid) begin
        pc       <= {redirect_pc[63:3], 3'b000};
        drop_cnt <= in_flight - CW'(resp_ok);
      end else begin
        if (req_hs)
          pc <= pc + 64'd8;
        if (resp_ok && (drop_cnt != '0))
          drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      skid_cnt <= '0;
    end else if (redirect_valid) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      skid_cnt <= '0;
    end else begin
      if (skid_wr)  wr_ptr <= wr_ptr + 1'b1;
      if (skid_pop) rd_ptr <= rd_ptr + 1'b1;
      skid_cnt <= skid_cnt + CW'(skid_wr) - CW'(skid_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (skid_wr) skid_mem[wr_ptr] <= ic_resp_data;
  end
endmodule

// File: tb/tb_if_fetch_sequencer.sv
// Bench for if_fetch_sequencer: directed scenarios, a queue-based reference model checked
// every cycle, and literal expectations for the headline behaviours.
module tb_if_fetch_sequencer;
  localparam int DEPTH = 4;
  localparam logic [63:0] RPC = 64'h1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0, redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        ic_req_valid, ic_req_ready = 1'b0;
  logic [63:0] ic_req_addr;
  logic        ic_resp_valid = 1'b0;
  logic [63:0] ic_resp_data = '0;
  logic        enq_valid, enq_ready = 1'b0;
  logic [63:0] enq_data, fetch_pc;
  logic        err_unexpected_resp;

  if_fetch_sequencer #(.RESET_PC(RPC), .SKID_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
    .fetch_pc(fetch_pc), .err_unexpected_resp(err_unexpected_resp)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // Reference model: architectural state only.
  logic [63:0] m_pc;
  bit          m_fetching, m_err;
  int          m_inflight, m_drop;
  logic [63:0] m_q[$];

  // I-cache responder and observation logs.
  logic [63:0] pend_a[$];
  int          pend_t[$];
  int          tcount, resp_delay;
  logic [63:0] req_log[$], enq_log[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_log(input string nm, input logic [63:0] q[$], input int idx,
                         input logic [63:0] exp);
    if (idx >= q.size()) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: only %0d entries, wanted index %0d = %h", nm, q.size(), idx, exp);
    end else chk(nm, q[idx], exp);
  endtask

  function automatic bit exp_req_v();
    return m_fetching && !redirect_valid && (m_inflight + m_q.size() < DEPTH);
  endfunction

  function automatic bit exp_enq_v();
    return (m_q.size() > 0) && !redirect_valid;
  endfunction

  task automatic model_init();
    m_pc = RPC; m_fetching = 0; m_err = 0; m_inflight = 0; m_drop = 0;
    m_q.delete(); pend_a.delete(); pend_t.delete();
    req_log.delete(); enq_log.delete();
    tcount = 0;
  endtask

  task automatic model_step();
    bit hs, pop, ok;
    hs  = exp_req_v() && ic_req_ready;
    pop = exp_enq_v() && enq_ready;
    ok  = ic_resp_valid && (m_inflight > 0);
    if (ic_resp_valid && !ok) m_err = 1;
    if (hs) begin
      pend_a.push_back(m_pc);
      pend_t.push_back(tcount + resp_delay);
    end
    if (redirect_valid) begin
      m_drop = m_inflight - int'(ok);
      m_q.delete();
      m_pc = {redirect_pc[63:3], 3'b000};
    end else begin
      if (pop) void'(m_q.pop_front());
      if (ok) begin
        if (m_drop > 0) m_drop--;
        else m_q.push_back(ic_resp_data);
      end
      if (hs) m_pc = m_pc + 64'd8;
    end
    m_inflight += int'(hs) - int'(ok);
    m_fetching = fetch_en;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    tcount++;
    #1;
    if (rst_n && pend_a.size() > 0 && pend_t[0] <= tcount) begin
      ic_resp_valid = 1'b1;
      ic_resp_data  = pend_a.pop_front();
      void'(pend_t.pop_front());
    end else begin
      ic_resp_valid = 1'b0;
      ic_resp_data  = '0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    ic_req_ready = 1'b0; enq_ready = 1'b0; ic_resp_valid = 1'b0;
    resp_delay = 2;
    model_init();
    ticks(2);
    rst_n = 1'b1;
    #1;
    chk("rst_req_valid", 64'(ic_req_valid), 64'd0);
    chk("rst_enq_valid", 64'(enq_valid), 64'd0);
    chk("rst_fetch_pc", fetch_pc, RPC);
    chk("rst_err", 64'(err_unexpected_resp), 64'd0);
  endtask

  // Per-cycle comparison against the model, plus handshake logging.
  always @(negedge clk) begin
    chk("cyc_req_valid", 64'(ic_req_valid), 64'(exp_req_v()));
    chk("cyc_fetch_pc", fetch_pc, m_pc);
    chk("cyc_enq_valid", 64'(enq_valid), 64'(exp_enq_v()));
    chk("cyc_err", 64'(err_unexpected_resp), 64'(m_err));
    if (exp_req_v()) chk("cyc_req_addr", ic_req_addr, m_pc);
    if (exp_enq_v()) chk("cyc_enq_data", enq_data, m_q[0]);
    if (ic_req_valid && ic_req_ready) req_log.push_back(ic_req_addr);
    if (enq_valid && enq_ready) enq_log.push_back(enq_data);
  end

  initial begin
    int n10;
    bit pat_rdy[16] = '{1,1,0,1,1,1,0,0,1,0,1,1,1,1,0,1};
    bit pat_enq[13] = '{1,0,1,1,0,0,1,1,1,0,1,1,0};
    model_init();
    resp_delay = 2;

    // Streaming: one packet per cycle, data follows address.
    do_reset();
    fetch_en = 1; ic_req_ready = 1; enq_ready = 1;
    ticks(10);
    n10 = enq_log.size();
    ticks(10);
    chk_log("t1_req0", req_log, 0, 64'h1000);
    chk_log("t1_req1", req_log, 1, 64'h1008);
    chk_log("t1_req2", req_log, 2, 64'h1010);
    chk_log("t1_enq0", enq_log, 0, 64'h1000);
    chk_log("t1_enq2", enq_log, 2, 64'h1010);
    chk("t1_rate", 64'(enq_log.size() - n10), 64'd10);

    // Backpressure: credits stop issue at SKID_DEPTH.
    do_reset();
    fetch_en = 1; ic_req_ready = 1; enq_ready = 0;
    ticks(15);
    chk("t2_req_count", 64'(req_log.size()), 64'd4);
    chk("t2_req_valid", 64'(ic_req_valid), 64'd0);
    chk("t2_head", enq_data, 64'h1000);
    enq_ready = 1;
    ticks(10);
    chk_log("t2_pop0", enq_log, 0, 64'h1000);
    chk_log("t2_pop3", enq_log, 3, 64'h1018);
    chk_log("t2_resume", req_log, 4, 64'h1020);

    // Redirect with three requests outstanding.
    do_reset();
    resp_delay = 10;
    fetch_en = 1; ic_req_ready = 1; enq_ready = 1;
    ticks(4);
    ic_req_ready = 0;
    redirect_valid = 1; redirect_pc = 64'h2004;
    tick();
    redirect_valid = 0; ic_req_ready = 1;
    #1;
    chk("t3_addr", ic_req_addr, 64'h2000);
    tick();
    chk("t3_pc_after", fetch_pc, 64'h2008);
    ticks(30);
    chk_log("t3_first_enq", enq_log, 0, 64'h2000);

    // Redirect coinciding with a response, skid non-empty.
    do_reset();
    fetch_en = 1; ic_req_ready = 1; enq_ready = 0;
    ticks(4);
    ic_req_ready = 0;
    redirect_valid = 1; redirect_pc = 64'h3000;
    #1;
    chk("t4_enq_during_redir", 64'(enq_valid), 64'd0);
    chk("t4_resp_present", 64'(ic_resp_valid), 64'd1);
    tick();
    redirect_valid = 0;
    #1;
    chk("t4_enq_after_flush", 64'(enq_valid), 64'd0);
    ic_req_ready = 1; enq_ready = 1;
    ticks(20);
    chk_log("t4_first_enq", enq_log, 0, 64'h3000);

    // Unexpected response sets a sticky error.
    do_reset();
    pend_a.push_back(64'hDEAD_BEEF); pend_t.push_back(tcount);
    ticks(2);
    chk("t5_err_set", 64'(err_unexpected_resp), 64'd1);
    chk("t5_enq_idle", 64'(enq_valid), 64'd0);
    ticks(4);
    chk("t5_err_sticky", 64'(err_unexpected_resp), 64'd1);

    // Wraparound at top of address space, then stop fetching mid-stream.
    do_reset();
    fetch_en = 1; ic_req_ready = 1; enq_ready = 1;
    redirect_valid = 1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    redirect_valid = 0;
    #1;
    chk("t6_addr_top", ic_req_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    tick();
    chk("t6_wrap_pc", fetch_pc, 64'h0);
    chk("t6_wrap_addr", ic_req_addr, 64'h0);
    ticks(6);
    fetch_en = 0;
    ticks(20);
    chk("t6_stopped", 64'(ic_req_valid), 64'd0);
    chk("t6_all_delivered", 64'(enq_log.size()), 64'(req_log.size()));
    chk_log("t6_enq0", enq_log, 0, 64'hFFFF_FFFF_FFFF_FFF8);
    chk_log("t6_enq1", enq_log, 1, 64'h0);

    // Mixed handshake patterns with redirects, checked by the model each cycle.
    do_reset();
    fetch_en = 1;
    for (int i = 0; i < 80; i++) begin
      ic_req_ready   = pat_rdy[i % 16];
      enq_ready      = pat_enq[i % 13];
      resp_delay     = 1 + (i % 3);
      redirect_valid = (i == 20) || (i == 41) || (i == 42);
      redirect_pc    = (i == 20) ? 64'h5000 : 64'h7FF8 + 64'(i);
      if (i == 60) fetch_en = 0;
      tick();
    end
    redirect_valid = 0; enq_ready = 1;
    ticks(20);
    chk("mix_drained", 64'(enq_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/if_fetch_sequencer.md
Name: if_fetch_sequencer

Overview:
Producer-side fetch sequencer that drives the instruction fetch buffer's enqueue port. Generates sequential 8-byte-aligned fetch addresses, issues them to the I-cache over a valid/ready request channel, and collects in-order 64-bit responses (two 32-bit instructions) in an internal skid FIFO. Entries drain from the skid FIFO into the fetch buffer via enq_valid/enq_ready. A credit check guarantees every outstanding response has a skid slot, so the response channel has no backpressure. Redirects flush the sequencer and discard stale in-flight responses.

Parameters:
RESET_PC, 64'h0000_0000_0000_1000, fetch PC after reset; bits [2:0] must be zero.
SKID_DEPTH, 4, skid FIFO entries and max (in_flight + skid occupancy); power of two, >=2.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
fetch_en  in  1  permit new I-cache requests
redirect_valid  in  1  flush and restart at redirect_pc
redirect_pc  in  64  new fetch target; bits [2:0] ignored
ic_req_valid  out  1  I-cache request valid
ic_req_addr  out  64  I-cache request address, 8-byte aligned
ic_req_ready  in  1  I-cache accepts request
ic_resp_valid  in  1  I-cache response valid; in order, no ready
ic_resp_data  in  64  fetch packet
enq_valid  out  1  fetch packet valid toward buffer
enq_data  out  64  fetch packet toward buffer
enq_ready  in  1  buffer accepts packet
fetch_pc  out  64  current next-request PC
err_unexpected_resp  out  1  sticky: response seen with in_flight==0

Behaviour:
- Clock clk; reset rst_n, asynchronous, active-low.
- Reset values: pc=RESET_PC, state=IDLE, in_flight=0, drop_cnt=0, skid empty, err_unexpected_resp=0. Hence ic_req_valid=0, enq_valid=0, fetch_pc=RESET_PC. Reset mid-operation discards everything; later responses to pre-reset requests are the I-cache's responsibility.
- Counter widths: $clog2(SKID_DEPTH)+1 bits for in_flight, drop_cnt, skid count.
- FSM: IDLE -> FETCH when fetch_en=1; FETCH -> IDLE when fetch_en=0. Outstanding responses still complete and drain in IDLE.
- ic_req_valid = (state==FETCH) & !redirect_valid & (in_flight + skid_count < SKID_DEPTH). ic_req_addr = pc. ic_req_valid is not held once asserted; the I-cache samples only on handshake.
- Request handshake (ic_req_valid & ic_req_ready): pc <= pc + 8, modulo 2^64. in_flight += 1.
- Response: in_flight -= 1 every cycle ic_resp_valid=1. Simultaneous request handshake and response leaves in_flight net unchanged. If drop_cnt>0, decrement drop_cnt and discard the data. Otherwise write data to the skid tail.
- Response with in_flight==0: ignore it, set err_unexpected_resp (cleared only by reset).
- Skid FIFO is first-word fall-through: enq_valid = !empty & !redirect_valid, enq_data = head. Pop on enq_valid & enq_ready. Latency from response to enq_valid is 1 cycle. A write and a pop in the same cycle are allowed at any occupancy. Overflow is impossible by the credit check.
- Redirect has the highest priority, takes 1 cycle, and works in either state:
  - pc <= {redirect_pc[63:3],3'b000}
  - skid flushed
  - no request issued
  - no enq pop
  - drop_cnt <= in_flight - ic_resp_valid; the same-cycle response is also discarded, and the existing drop_cnt is subsumed.
  - in_flight is updated normally.
  - Requests at the new pc may issue the next cycle while stale responses are still being dropped.
- Back-to-back redirects: the last one wins; the drop accounting above still holds.
- Invariant: drop_cnt <= in_flight <= SKID_DEPTH.

Test Plan:
1. RESET_PC=0x1000, fetch_en=1, ic_req_ready=1, enq_ready=1, responses 2 cycles after request with data=addr -> ic_req_addr 0x1000,0x1008,0x1010..., enq_data the same sequence, one packet/cycle steady state.
2. SKID_DEPTH=4, enq_ready=0 -> exactly 4 requests accepted, then ic_req_valid=0. Skid holds 4 entries. Raise enq_ready -> 4 pops in order, issue resumes.
3. 3 requests in flight, redirect_pc=0x2004 -> next ic_req_addr=0x2000. The 3 stale responses are not enqueued. First enq_data is the 0x2000 packet; fetch_pc=0x2008 after that handshake.
4. Redirect in the same cycle as a response with in_flight=2 -> both old responses dropped (drop_cnt=1 after redirect), enq_valid=0 during the redirect cycle even with skid non-empty.
5. ic_resp_valid with in_flight=0 -> err_unexpected_resp=1 and stays 1, enq_valid stays 0. Reset clears it.
6. Redirect to 0xFFFF_FFFF_FFFF_FFF8, one request accepted -> next ic_req_addr=0x0. fetch_en=0 mid-stream -> requests stop, outstanding packets still delivered.
